// File: rtl/uart_tx_if.sv
// FIFO read-port bundle between a byte FIFO and the UART transmitter.
// The FIFO side is the master; the transmitter pops through the slave view.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  fifo_rd_en;

    modport master (
        output fifo_data,
        output fifo_empty,
        input  fifo_rd_en
    );

    modport slave (
        input  fifo_data,
        input  fifo_empty,
        output fifo_rd_en
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8N1-style frames (start, DATA_WIDTH bits LSB first,
// one stop bit, no parity) fed from a registered-output byte FIFO.
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_WIDTH   = 8
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      tx_en_i,
    uart_tx_if.slave  fifo,
    output logic      tx_o,
    output logic      busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] LP_CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LP_IDX_MAX = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_rd_en;

    logic w_bit_end;
    logic w_go;

    assign w_bit_end = (r_cnt == LP_CNT_MAX);
    assign w_go      = tx_en_i & ~fifo.fifo_empty;

    assign tx_o            = r_tx;
    assign busy_o          = r_busy;
    assign fifo.fifo_rd_en = r_rd_en;

    // Frame sequencer; every output is a register updated on state or bit edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_rd_en <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_rd_en <= 1'b0;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    if (w_go) begin
                        // Pop is raised for the LOAD cycle only.
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // FIFO read data is already valid here; later changes
                    // on the port cannot reach the frame.
                    r_shift <= fifo.fifo_data;
                    r_rd_en <= 1'b0;
                    r_tx    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_START;
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == LP_IDX_MAX) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_idx   <= r_idx + IW'(1);
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a fast instance (4 clocks/bit) for
// framing, gating and reset cases, and a default instance for frame length.
module tb_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    logic tx_en;

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_WIDTH(8)) bus  ();
    uart_tx_if #(.DATA_WIDTH(8)) bus2 ();

    logic w_tx, w_busy, w_tx_d, w_busy_d;

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .tx_en_i (tx_en),
        .fifo    (bus.slave),
        .tx_o    (w_tx),
        .busy_o  (w_busy)
    );

    uart_tx dut_d (
        .clk_i   (clk),
        .rst_i   (rst),
        .tx_en_i (tx_en),
        .fifo    (bus2.slave),
        .tx_o    (w_tx_d),
        .busy_o  (w_busy_d)
    );

    // Byte FIFO models with registered read data.
    logic [7:0] mem  [0:15];
    logic [7:0] mem2 [0:15];
    int wr = 0, rp = 0, wr2 = 0, rp2 = 0;
    int pops = 0, viol = 0, cyc = 0;

    assign bus.fifo_data   = mem[rp[3:0]];
    assign bus.fifo_empty  = (rp == wr);
    assign bus2.fifo_data  = mem2[rp2[3:0]];
    assign bus2.fifo_empty = (rp2 == wr2);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rd_en) begin
            if (bus.fifo_empty) viol <= viol + 1;
            else rp <= rp + 1;
            pops <= pops + 1;
        end
        if (bus2.fifo_rd_en) begin
            if (bus2.fifo_empty) viol <= viol + 1;
            else rp2 <= rp2 + 1;
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr[3:0]] = b;
        wr = wr + 1;
    endtask

    // Wait for a start bit, then check every cycle of the frame.
    task automatic check_frame(input string tag, input logic [7:0] b,
                               input int drop_bit, output int fall_c,
                               output int stop_c);
        int t;
        int bad;
        logic [9:0] f;
        t = 0;
        bad = 0;
        f = {1'b1, b, 1'b0};
        fall_c = -1;
        stop_c = -1;
        while (w_tx !== 1'b0 && t < 60) begin
            tick();
            t++;
        end
        if (w_tx !== 1'b0) begin
            chk({tag, "_timeout"}, 32'd1, 32'd0);
            return;
        end
        fall_c = cyc;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                if (i == 9 && c == 0) stop_c = cyc;
                if (i == drop_bit && c == 0) tx_en = 1'b0;
                if (w_tx !== f[i]) bad++;
                if (w_busy !== 1'b1) bad++;
                tick();
            end
        end
        chk({tag, "_bits"}, bad, 0);
        chk({tag, "_end_busy"}, {31'd0, w_busy}, 0);
    endtask

    initial begin
        int n, f1, s1, f2, s2, bad, t, len;
        logic [9:0] fr;

        rst = 1'b1;
        tx_en = 1'b0;
        repeat (3) tick();
        chk("rst_tx", {31'd0, w_tx}, 1);
        chk("rst_busy", {31'd0, w_busy}, 0);
        chk("rst_rd", {31'd0, bus.fifo_rd_en}, 0);
        rst = 1'b0;
        tick();

        // Single byte 0xA5 with latency check.
        push(8'hA5);
        tx_en = 1'b1;
        n = cyc;
        tick();
        chk("a5_load_rd", {31'd0, bus.fifo_rd_en}, 1);
        chk("a5_load_busy", {31'd0, w_busy}, 1);
        check_frame("a5", 8'hA5, -1, f1, s1);
        chk("a5_lat", f1 - n, 2);
        chk("a5_pops", pops, 1);

        // Back-to-back 0x00 then 0xFF.
        push(8'h00);
        push(8'hFF);
        check_frame("b00", 8'h00, -1, f1, s1);
        check_frame("bff", 8'hFF, -1, f2, s2);
        chk("b2b_gap", f2 - s1, CPB + 2);
        chk("b2b_pops", pops, 3);

        // Empty FIFO with enable held.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (w_tx !== 1'b1 || w_busy !== 1'b0 || bus.fifo_rd_en !== 1'b0)
                bad++;
            tick();
        end
        chk("empty_idle", bad, 0);

        // Gating by tx_en_i; enable dropped mid-frame.
        tx_en = 1'b0;
        push(8'h3C);
        push(8'h55);
        push(8'h81);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (w_tx !== 1'b1 || w_busy !== 1'b0 || bus.fifo_rd_en !== 1'b0)
                bad++;
            tick();
        end
        chk("gate_idle", bad, 0);
        tx_en = 1'b1;
        n = cyc;
        check_frame("g3c", 8'h3C, 4, f1, s1);
        chk("g3c_lat", f1 - n, 2);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (w_tx !== 1'b1 || w_busy !== 1'b0) bad++;
            tick();
        end
        chk("g_no_second", bad, 0);
        chk("g_pops", pops, 4);

        // Reset during data bit 3 of 0x55.
        tx_en = 1'b1;
        t = 0;
        while (w_tx !== 1'b0 && t < 60) begin
            tick();
            t++;
        end
        chk("r55_fall", {31'd0, w_tx}, 0);
        repeat (17) tick();
        chk("r55_bit3", {31'd0, w_tx}, 0);
        rst = 1'b1;
        tick();
        chk("r55_tx", {31'd0, w_tx}, 1);
        chk("r55_busy", {31'd0, w_busy}, 0);
        chk("r55_rd", {31'd0, bus.fifo_rd_en}, 0);
        rst = 1'b0;
        n = cyc;
        check_frame("r81", 8'h81, -1, f1, s1);
        chk("r81_lat", f1 - n, 2);
        chk("r_pops", pops, 6);

        // Default parameters, 0x5A, frame length.
        mem2[wr2[3:0]] = 8'h5A;
        wr2 = wr2 + 1;
        t = 0;
        while (w_tx_d !== 1'b0 && t < 20) begin
            tick();
            t++;
        end
        chk("d_fall", {31'd0, w_tx_d}, 0);
        len = 0;
        fr = '0;
        while (w_busy_d === 1'b1 && len < 1040) begin
            if (len % 104 == 52) fr[len / 104] = w_tx_d;
            len++;
            tick();
        end
        chk("d_len", len, 1040);
        chk("d_end_busy", {31'd0, w_busy_d}, 0);
        chk("d_frame", {22'd0, fr}, {22'd0, 1'b1, 8'h5A, 1'b0});

        chk("pop_empty", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, clk_i cycles per serial bit (12 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter DATA_WIDTH, default 8, data bits per frame, matching the byte FIFO feeding this block.
REQ-003 clk_i  input  1  single clock; every register is clocked on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 tx_en_i  input  1  high permits a new frame to start.
REQ-006 fifo_data_i  input  DATA_WIDTH  byte from the FIFO read port; registered there, valid one cycle after the FIFO goes non-empty or after a pop.
REQ-007 fifo_empty_i  input  1  FIFO empty flag.
REQ-008 fifo_rd_en_o  output  1  pop strobe to the FIFO, one cycle per frame.
REQ-009 tx_o  output  1  serial line, idle high.
REQ-010 busy_o  output  1  high while a frame is in progress (states LOAD through STOP).

Function
REQ-011 The block SHALL use the states IDLE, LOAD, START, DATA and STOP.
REQ-012 IDLE: tx_o=1 and busy_o=0; if tx_en_i=1 and fifo_empty_i=0, the next state SHALL be LOAD, else IDLE.
REQ-013 LOAD lasts 1 cycle: fifo_data_i is captured into the shift register, fifo_rd_en_o=1, and the next state is START.
REQ-014 fifo_rd_en_o SHALL be high only in LOAD, exactly 1 cycle per frame, and never while fifo_empty_i=1.
REQ-015 START: tx_o=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-016 DATA: DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles; the bit index SHALL count 0..DATA_WIDTH-1 and then go to STOP.
REQ-017 STOP: tx_o=1 for exactly CLKS_PER_BIT cycles, then IDLE; no parity bit.
REQ-018 tx_o SHALL be driven from a register, glitch-free, and SHALL change only on state or bit boundaries.
REQ-019 The baud counter SHALL count 0..CLKS_PER_BIT-1, reload to 0 on every bit boundary, and never wrap within a bit.
REQ-020 Latency: the first IDLE cycle with tx_en_i=1 and fifo_empty_i=0 is cycle n; LOAD is cycle n+1; tx_o falls at cycle n+2.
REQ-021 Back-to-back frames: STOP, then 1 IDLE cycle, then LOAD, so the line stays high for exactly CLKS_PER_BIT+2 cycles between frames.
REQ-022 tx_en_i deasserted mid-frame SHALL NOT abort the frame; it only blocks the IDLE to LOAD transition.
REQ-023 A change of fifo_data_i after LOAD SHALL NOT affect the frame in progress.
REQ-024 Changes of fifo_empty_i outside IDLE SHALL be ignored.
REQ-025 A frame SHALL occupy exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.

Reset
REQ-026 While rst_i=1 at a clock edge, the next state SHALL be IDLE, with tx_o=1, busy_o=0, fifo_rd_en_o=0, and the counters and shift register cleared.
REQ-027 Reset mid-frame SHALL abort the frame; tx_o=1 from the cycle after the reset edge, and the aborted byte is not re-sent.
REQ-028 The first cycle after rst_i falls SHALL follow the IDLE rules, with no spurious pop or start bit.

Verification
REQ-029 Single byte, CLKS_PER_BIT=4, FIFO holds 0xA5, tx_en_i=1 -> tx_o sequence 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; one fifo_rd_en_o pulse; busy_o low after STOP.
REQ-030 Back-to-back, FIFO holds 0x00 then 0xFF -> two frames; the line is high for 6 cycles between the first stop start and the next start bit; exactly 2 pops.
REQ-031 Empty FIFO with tx_en_i=1 for 100 cycles -> tx_o=1, fifo_rd_en_o=0 and busy_o=0 throughout.
REQ-032 Gating: FIFO holds 0x3C and tx_en_i=0 -> no activity; tx_en_i set at cycle n -> tx_o falls at n+2; tx_en_i cleared during DATA -> the frame completes and no second frame starts.
REQ-033 rst_i pulsed for 1 cycle during bit 3 of 0x55 -> tx_o=1 on the next cycle; the next frame starts from the next FIFO byte.
REQ-034 Default parameters, byte 0x5A -> frame length exactly 1040 cycles, measured from the start-bit falling edge to the end of the stop bit.
